fp_sqrt_iter_core: RTL and testbench

Iterative digit-recurrence unsigned square-root engine for the FP square-root unit.
- Sits directly downstream of the fp_sqrt wrapper. The wrapper drives the aligned radicand and start; it consumes result, remainder and done for rounding and sticky generation.
- Computes Q = floor(sqrt(R·2^W)) and the exact remainder R·2^W − Q². W is the radicand width.
- Radicand is fixed-point in [1,4) with W−2 fraction bits. Result is in [1,2) with W−1 fraction bits.

---
 rtl/fp_sqrt_iter_core.sv | 134 +++++++++++++
 tb/tb_fp_sqrt_iter_core.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/fp_sqrt_iter_core.sv
// Iterative digit-recurrence unsigned square root: Q = floor(sqrt(R*2^W)), remainder = R*2^W - Q^2.
// Define FP_SQRT_RADIX4_EN to retire two root bits per cycle (ceil(W/2) cycles instead of W).

module fp_sqrt_step #(
  parameter int W = 57
) (
  input  logic [W+1:0]   p_in,
  input  logic [W-1:0]   q_in,
  input  logic [2*W-1:0] s_in,
  output logic [W+1:0]   p_out,
  output logic [W-1:0]   q_out,
  output logic [2*W-1:0] s_out
);
  logic [W+3:0] cand, trial;
  logic [W+1:0] diff;
  logic         ge;

  assign cand  = {p_in, s_in[2*W-1:2*W-2]};
  assign trial = {2'b00, q_in, 2'b01};
  assign ge    = cand >= trial;
  // the accepted difference is below 2Q+1, so the low W+2 bits are exact
  assign diff  = cand[W+1:0] - trial[W+1:0];
  assign p_out = ge ? diff : cand[W+1:0];
  assign q_out = {q_in[W-2:0], ge};
  assign s_out = {s_in[2*W-3:0], 2'b00};
endmodule

module fp_sqrt_iter_core #(
  parameter int DATA_WIDTH = 57
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] radicand,
  output logic [DATA_WIDTH-1:0] result,
  output logic [DATA_WIDTH:0]   remainder,
  output logic                  sticky,
  output logic                  done,
  output logic                  busy
);
  localparam int W = DATA_WIDTH;
`ifdef FP_SQRT_RADIX4_EN
  localparam int LPC = 2;
`else
  localparam int LPC = 1;
`endif
  localparam int NSTEPS    = (W + LPC - 1) / LPC;
  localparam int CW        = $clog2(NSTEPS + 1);
  localparam bit ODD_FIRST = (LPC == 2) && (W % 2 == 1);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t           state;
  logic [2*W-1:0]   s;
  logic [W+1:0]     p;
  logic [W-1:0]     q;
  logic [CW-1:0]    cnt;

  logic [LPC:0][W+1:0]   p_c;
  logic [LPC:0][W-1:0]   q_c;
  logic [LPC:0][2*W-1:0] s_c;
  logic [W+1:0]          p_nxt;
  logic [W-1:0]          q_nxt;
  logic [2*W-1:0]        s_nxt;
  logic                  single;

  assign p_c[0] = p;
  assign q_c[0] = q;
  assign s_c[0] = s;

  for (genvar g = 0; g < LPC; g++) begin : g_step
    fp_sqrt_step #(.W(W)) u_step (
      .p_in  (p_c[g]),
      .q_in  (q_c[g]),
      .s_in  (s_c[g]),
      .p_out (p_c[g+1]),
      .q_out (q_c[g+1]),
      .s_out (s_c[g+1])
    );
  end

  // odd width in the two-step build: the first cycle retires one bit so the total is W
  assign single = ODD_FIRST && (cnt == CW'(NSTEPS));
  assign p_nxt  = single ? p_c[1] : p_c[LPC];
  assign q_nxt  = single ? q_c[1] : q_c[LPC];
  assign s_nxt  = single ? s_c[1] : s_c[LPC];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      s         <= '0;
      p         <= '0;
      q         <= '0;
      cnt       <= '0;
      result    <= '0;
      remainder <= '0;
      sticky    <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        // also aborts any operation in flight; its done is never issued
        s     <= {radicand, {W{1'b0}}};
        p     <= '0;
        q     <= '0;
        cnt   <= CW'(NSTEPS);
        state <= ITER;
        busy  <= 1'b1;
      end else begin
        case (state)
          ITER: begin
            p   <= p_nxt;
            q   <= q_nxt;
            s   <= s_nxt;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              state     <= DONE;
              done      <= 1'b1;
              result    <= q_nxt;
              remainder <= p_nxt[W:0];
              sticky    <= |p_nxt[W:0];
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: busy <= 1'b0;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_fp_sqrt_iter_core.sv
// Scoreboard bench for fp_sqrt_iter_core at W=8: directed radicands with hand-computed roots.
module tb_fp_sqrt_iter_core;
  localparam int W = 8;
`ifdef FP_SQRT_RADIX4_EN
  localparam int LAT = (W + 1) / 2;
`else
  localparam int LAT = W;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] radicand = '0;
  logic [W-1:0] result;
  logic [W:0]   remainder;
  logic         sticky, done, busy;

  fp_sqrt_iter_core #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .radicand  (radicand),
    .result    (result),
    .remainder (remainder),
    .sticky    (sticky),
    .done      (done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic [W:0]   rem;
    int           t0;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  // caller is positioned at a negedge; start is sampled by the next posedge
  task automatic issue(input logic [W-1:0] r, input bit track,
                       input logic [W-1:0] eres, input logic [W:0] erem);
    exp_t e;
    start    = 1'b1;
    radicand = r;
    if (track) begin
      e.res = eres; e.rem = erem; e.t0 = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done) break;
    end
    if (k == 100) chk("done_timeout", 0, 1);
  endtask

  // monitor: every done pulse must match the oldest outstanding expectation
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("remainder", remainder, e.rem);
        chk("sticky", sticky, (e.rem != 0));
        chk("latency", cyc - e.t0, LAT);
        chk("done_width", done_prev, 0);
      end
    end
    done_prev <= done;
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_result", result, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_done", done, 0);

    // 1.0 -> 1.0 exact, then 1.5 started in the done cycle
    issue(8'h40, 1, 8'h80, 9'd0);
    wait_done();
    issue(8'h60, 1, 8'h9C, 9'd240);
    wait_done();
    @(negedge clk);
    issue(8'h80, 1, 8'hB5, 9'd7);
    wait_done();
    @(negedge clk);
    issue(8'hC0, 1, 8'hDD, 9'd311);
    wait_done();
    @(negedge clk);
    issue(8'h64, 1, 8'hA0, 9'd0);
    wait_done();
    @(negedge clk);
    issue(8'hFF, 1, 8'hFF, 9'd255);
    wait_done();
    repeat (2) @(negedge clk);

    // abort: the first op must never report, outputs hold the last result meanwhile
    issue(8'h40, 0, '0, '0);
    @(negedge clk);
    chk("hold_result", result, 8'hFF);
    chk("hold_remainder", remainder, 255);
    chk("busy_iter", busy, 1);
    issue(8'h80, 1, 8'hB5, 9'd7);
    wait_done();
    repeat (3) @(negedge clk);
    chk("busy_idle", busy, 0);

    // reset in cycle 4 of an op: outputs clear at once, no done follows
    issue(8'h60, 0, '0, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_result", result, 0);
    chk("mid_rst_remainder", remainder, 0);
    chk("mid_rst_sticky", sticky, 0);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 5) @(negedge clk);
    chk("post_rst_busy", busy, 0);

    issue(8'h40, 1, 8'h80, 9'd0);
    wait_done();
    repeat (2) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
